// File: rtl/fishingrod_round_ctrl_if.sv
// Handshake bundle for the round/step sequencer: run control inputs and
// round/step/select outputs.
interface fishingrod_round_ctrl_if #(
    parameter int RW   = 5,
    parameter int SW   = 3,
    parameter int SELW = 4
) ();
    logic            start;
    logic            mode;
    logic            stall;
    logic            busy;
    logic [RW-1:0]   round;
    logic [SW-1:0]   step;
    logic            first_round;
    logic            last_round;
    logic            ready;
    logic [SELW-1:0] sels;
    logic [SELW-1:0] selk;

    modport master (
        output start, mode, stall,
        input  busy, round, step, first_round, last_round, ready, sels, selk
    );

    modport slave (
        input  start, mode, stall,
        output busy, round, step, first_round, last_round, ready, sels, selk
    );
endinterface

// File: rtl/fishingrod_round_ctrl.sv
// Round/step sequencer for an iterated cipher datapath: walks rounds up
// (encrypt) or down (decrypt), STEPS steps per round, with per-step selects.
module fishingrod_round_ctrl #(
    parameter int ROUNDS = 19,
    parameter int STEPS  = 8,
    parameter int RW     = 5,
    parameter int SW     = 3,
    parameter int SELW   = 4,
    parameter logic [STEPS*2*SELW-1:0] SEL_TABLE = 64'h0C18_3879_0592_B070
) (
    input logic ck,
    input logic rst,
    fishingrod_round_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);
    localparam logic [SW-1:0] SLAST = SW'(STEPS - 1);

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [SW-1:0] step_q,  step_d;
    logic          mode_q,  mode_d;
    logic          ready_q, ready_d;

    logic          busy;
    logic [RW-1:0] start_idx, end_idx;
    logic [2*SELW-1:0] sel_entry;

    // Table padded to the full step index range so any step value is a legal index.
    logic [2*SELW-1:0] sel_tab [2**SW];

    for (genvar i = 0; i < 2**SW; i++) begin : g_tab
        if (i < STEPS) begin : g_used
            assign sel_tab[i] = SEL_TABLE[i*2*SELW +: 2*SELW];
        end else begin : g_pad
            assign sel_tab[i] = '0;
        end
    end

    assign busy      = (state_q == RUN);
    assign start_idx = mode_q ? RLAST : '0;
    assign end_idx   = mode_q ? '0 : RLAST;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = step_q;
        mode_d  = mode_q;
        ready_d = 1'b0;
        // start overrides everything, including the final advance of a run.
        if (bus.start) begin
            state_d = RUN;
            step_d  = '0;
            mode_d  = bus.mode;
            round_d = bus.mode ? RLAST : '0;
        end else if (state_q == RUN && !bus.stall) begin
            if (step_q != SLAST) begin
                step_d = step_q + 1'b1;
            end else begin
                step_d = '0;
                if (round_q == end_idx) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (mode_q) begin
                    round_d = round_q - 1'b1;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
        end
    end

    assign sel_entry       = busy ? sel_tab[step_q] : '0;
    assign bus.busy        = busy;
    assign bus.round       = round_q;
    assign bus.step        = step_q;
    assign bus.first_round = busy & (round_q == start_idx);
    assign bus.last_round  = busy & (round_q == end_idx);
    assign bus.ready       = ready_q;
    assign bus.sels        = sel_entry[2*SELW-1:SELW];
    assign bus.selk        = sel_entry[SELW-1:0];
endmodule

// File: tb/tb_fishingrod_round_ctrl.sv
// Bench for fishingrod_round_ctrl: position-counter reference model checked
// every cycle, directed literal scenarios, and a ROUNDS=1/STEPS=1 instance.
module tb_fishingrod_round_ctrl;
    localparam int ROUNDS = 19;
    localparam int STEPS  = 8;

    logic ck = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;

    fishingrod_round_ctrl_if #(.RW(5), .SW(3), .SELW(4)) bus ();
    fishingrod_round_ctrl_if #(.RW(1), .SW(1), .SELW(4)) ebus ();

    fishingrod_round_ctrl u_dut (.ck(ck), .rst(rst), .bus(bus));

    fishingrod_round_ctrl #(
        .ROUNDS(1), .STEPS(1), .RW(1), .SW(1), .SELW(4), .SEL_TABLE(8'hA5)
    ) u_edge (.ck(ck), .rst(rst), .bus(ebus));

    // {sels,selk} per step, written out entry by entry.
    logic [7:0] tab [8] = '{8'h70, 8'hB0, 8'h92, 8'h05, 8'h79, 8'h38, 8'h18, 8'h0C};

    // Reference: one linear position through the run instead of round/step counters.
    logic m_run, m_mode, m_ready;
    int   m_pos;

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_pos <= 0; m_mode <= 1'b0; m_ready <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            if (bus.start) begin
                m_run <= 1'b1; m_pos <= 0; m_mode <= bus.mode;
            end else if (m_run && !bus.stall) begin
                if (m_pos == ROUNDS*STEPS - 1) begin
                    m_run <= 1'b0; m_pos <= (ROUNDS-1)*STEPS; m_ready <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    function automatic logic [19:0] expv();
        int r, s;
        r = m_pos / STEPS;
        s = m_pos % STEPS;
        return {m_run, 5'(m_mode ? ROUNDS-1-r : r), 3'(s),
                m_run && (r == 0), m_run && (r == ROUNDS-1), m_ready,
                m_run ? tab[s] : 8'h00};
    endfunction

    function automatic logic [19:0] dutv();
        return {bus.busy, bus.round, bus.step, bus.first_round, bus.last_round,
                bus.ready, bus.sels, bus.selk};
    endfunction

    function automatic logic [13:0] edutv();
        return {ebus.busy, ebus.round, ebus.step, ebus.first_round, ebus.last_round,
                ebus.ready, ebus.sels, ebus.selk};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, let the rising edge sample, compare at the next falling edge.
    task automatic cyc(input logic s, input logic md, input logic st);
        bus.start = s; bus.mode = md; bus.stall = st;
        @(posedge ck);
        @(negedge ck);
        chk("cycle", 32'(dutv()), 32'(expv()));
    endtask

    task automatic ecyc(input logic s);
        ebus.start = s;
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic run_seq(input logic md, input int st0, input int sl, input int abort_e,
                           input int k1, input int k2,
                           output int bcnt, output int rcnt,
                           output logic [19:0] snap1, output logic [19:0] snap2);
        int rk;
        bcnt = 0; rcnt = 0; rk = -1; snap1 = '0; snap2 = '0;
        for (int k = 0; k < 700; k++) begin
            cyc(k == 0 || k == abort_e, md, k >= st0 && k < st0 + sl);
            if (bus.busy) bcnt++;
            if (bus.ready) begin
                rcnt++;
                if (rk < 0) rk = k;
            end
            if (k == k1) snap1 = dutv();
            if (k == k2) snap2 = dutv();
            if (rk >= 0 && k >= rk + 3) break;
        end
    endtask

    int bcnt, rcnt;
    logic [19:0] s1, s2;

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.stall = 1'b0;
        ebus.start = 1'b0; ebus.mode = 1'b0; ebus.stall = 1'b0;
        repeat (3) @(negedge ck);
        chk("reset_main", 32'(dutv()), 32'h0);
        chk("reset_edge", 32'(edutv()), 32'h0);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // Encrypt, no stalls.
        run_seq(1'b0, -10, 0, -1, 2, 151, bcnt, rcnt, s1, s2);
        chk("enc_busy_cycles", bcnt, 152);
        chk("enc_ready_pulses", rcnt, 1);
        chk("enc_r0_s2", 32'(s1), 32'({1'b1, 5'd0, 3'd2, 1'b1, 1'b0, 1'b0, 4'b1001, 4'b0010}));
        chk("enc_r18_s7", 32'(s2), 32'({1'b1, 5'd18, 3'd7, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100}));

        // Decrypt, no stalls.
        run_seq(1'b1, -10, 0, -1, 2, 151, bcnt, rcnt, s1, s2);
        chk("dec_busy_cycles", bcnt, 152);
        chk("dec_ready_pulses", rcnt, 1);
        chk("dec_r18_s2", 32'(s1), 32'({1'b1, 5'd18, 3'd2, 1'b1, 1'b0, 1'b0, 4'b1001, 4'b0010}));
        chk("dec_r0_s7", 32'(s2), 32'({1'b1, 5'd0, 3'd7, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100}));

        // Five stalled edges while at round 3 step 4.
        run_seq(1'b0, 29, 5, -1, 31, 157, bcnt, rcnt, s1, s2);
        chk("stall_busy_cycles", bcnt, 157);
        chk("stall_ready_pulses", rcnt, 1);
        chk("stall_frozen", 32'(s1), 32'({1'b1, 5'd3, 3'd4, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1001}));

        // Abort at round 10 step 2: restart sampled at edge 83.
        run_seq(1'b0, -10, 0, 83, 82, 83, bcnt, rcnt, s1, s2);
        chk("abort_busy_cycles", bcnt, 83 + 152);
        chk("abort_ready_pulses", rcnt, 1);
        chk("abort_before", 32'(s1), 32'({1'b1, 5'd10, 3'd2, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0010}));
        chk("abort_restart", 32'(s2), 32'({1'b1, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0000}));

        // Reset mid-run at round 7, asserted between clock edges.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (56) cyc(1'b0, 1'b0, 1'b0);
        chk("pre_reset_round7", 32'(bus.round), 32'd7);
        #2 rst = 1'b1;
        #1 chk("reset_immediate", 32'(dutv()), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bcnt = 0; rcnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'(k % 2), 1'(k % 3 == 0));
            if (bus.busy) bcnt++;
            if (bus.ready) rcnt++;
        end
        chk("post_reset_busy", bcnt, 0);
        chk("post_reset_ready", rcnt, 0);

        // Randomized traffic, model-checked every cycle.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b1;
                cyc(1'b0, 1'b0, 1'b0);
                rst = 1'b0;
            end
            cyc($urandom_range(0, 249) == 0, 1'($urandom), $urandom_range(0, 3) == 0);
        end

        // ROUNDS=1, STEPS=1 instance.
        bus.start = 1'b0; bus.stall = 1'b0;
        ecyc(1'b1);
        chk("edge_run", 32'(edutv()), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5}));
        ecyc(1'b0);
        chk("edge_ready", 32'(edutv()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0}));
        ecyc(1'b0);
        chk("edge_idle", 32'(edutv()), 32'h0);
        ecyc(1'b1);
        ecyc(1'b1);
        chk("edge_restart", 32'(edutv()), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5}));
        ecyc(1'b0);
        chk("edge_restart_ready", 32'(edutv()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
